// File: rtl/multichannel_decimator.sv
// N-channel runtime-ratio decimator: pick (last sample) or boxcar average with
// arithmetic shift and saturation. One output pulse per R input strobes.
module multichannel_decimator #(
  parameter  int W    = 19,
  parameter  int NCH  = 8,
  parameter  int RMAX = 256,
  localparam int RW   = $clog2(RMAX + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ready,
  input  logic [NCH*W-1:0] i_data,
  input  logic [RW-1:0]    i_ratio,
  input  logic             i_mode,
  input  logic [4:0]       i_shift,
  input  logic             i_sync,
  output logic [NCH*W-1:0] o_data,
  output logic             o_ready
);
  localparam int AW = W + $clog2(RMAX);
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic [RW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          ratio_q, ratio_d;
  logic                   mode_q, mode_d;
  logic [4:0]             shift_q, shift_d;
  logic signed [AW-1:0]   acc_q [NCH];
  logic signed [AW-1:0]   acc_d [NCH];
  logic [NCH*W-1:0]       data_q, data_d;
  logic                   ready_q, ready_d;

  logic [RW-1:0]          ratio_in, ratio_eff, cnt_eff;
  logic                   mode_eff, start, last;
  logic [4:0]             shift_eff;
  logic signed [AW-1:0]   sum [NCH];
  logic signed [AW-1:0]   shr [NCH];
  logic [NCH*W-1:0]       res;

  // A strobe that opens a group (after reset, sync or output) uses the live
  // config inputs, so an R=1 group completes with the ratio it was started with.
  always_comb begin
    if (i_ratio == '0)               ratio_in = RW'(1);
    else if (i_ratio > RW'(RMAX))    ratio_in = RW'(RMAX);
    else                             ratio_in = i_ratio;
    start     = i_sync || (cnt_q == '0);
    ratio_eff = start ? ratio_in : ratio_q;
    mode_eff  = start ? i_mode   : mode_q;
    shift_eff = start ? i_shift  : shift_q;
    cnt_eff   = i_sync ? '0 : cnt_q;
    last      = (cnt_eff == ratio_eff - RW'(1));
  end

  always_comb begin
    res = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      sum[k] = ((cnt_eff == '0) ? '0 : acc_q[k]) + AW'($signed(i_data[k*W +: W]));
      shr[k] = sum[k] >>> shift_eff;
      if (!mode_eff)          res[k*W +: W] = i_data[k*W +: W];
      else if (shr[k] > SAT_HI) res[k*W +: W] = SAT_HI[W-1:0];
      else if (shr[k] < SAT_LO) res[k*W +: W] = SAT_LO[W-1:0];
      else                      res[k*W +: W] = shr[k][W-1:0];
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    data_d  = data_q;
    ready_d = 1'b0;
    if (i_sync) cnt_d = '0;
    if (i_ready) begin
      if (start) begin
        ratio_d = ratio_in;
        mode_d  = i_mode;
        shift_d = i_shift;
      end
      for (int unsigned k = 0; k < NCH; k++) acc_d[k] = sum[k];
      if (last) begin
        cnt_d   = '0;
        ready_d = 1'b1;
        data_d  = res;
      end else begin
        cnt_d = cnt_eff + RW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      ratio_q <= ratio_in;
      mode_q  <= i_mode;
      shift_q <= i_shift;
      for (int unsigned k = 0; k < NCH; k++) acc_q[k] <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign o_data  = data_q;
  assign o_ready = ready_q;
endmodule

// File: tb/tb_multichannel_decimator.sv
// Directed bench for multichannel_decimator (NCH=2) with a group-queue reference
// model checked every cycle plus literal expectations per scenario.
module tb_multichannel_decimator;
  localparam int W    = 19;
  localparam int NCH  = 2;
  localparam int RMAX = 256;
  localparam int RW   = $clog2(RMAX + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ready = 1'b0;
  logic [NCH*W-1:0] data = '0;
  logic [RW-1:0]    ratio = RW'(1);
  logic             mode = 1'b0;
  logic [4:0]       shift = '0;
  logic             sync = 1'b0;
  logic [NCH*W-1:0] o_data;
  logic             o_ready;

  int n_assert = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  multichannel_decimator #(.W(W), .NCH(NCH), .RMAX(RMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ready(ready), .i_data(data),
    .i_ratio(ratio), .i_mode(mode), .i_shift(shift), .i_sync(sync),
    .o_data(o_data), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    logic signed [W-1:0] t;
    t = v;
    return longint'(t);
  endfunction

  function automatic longint och(input int k);
    logic [W-1:0] v;
    v = o_data[k*W +: W];
    return sx(v);
  endfunction

  // Reference model: collect the samples of the current group, evaluate once full.
  logic [NCH*W-1:0] grp[$];
  int               m_r;
  int               m_sh;
  bit               m_mode;
  logic [NCH*W-1:0] exp_data = '0;
  bit               exp_ready = 1'b0;

  function automatic int clampr(input int r);
    if (r == 0) return 1;
    if (r > RMAX) return RMAX;
    return r;
  endfunction

  function automatic logic [NCH*W-1:0] group_result();
    logic [NCH*W-1:0] r, word;
    logic [W-1:0]     v;
    longint           s, hi, lo;
    hi = (longint'(1) << (W-1)) - 1;
    lo = -(longint'(1) << (W-1));
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!m_mode) begin
        word = grp[grp.size()-1];
        r[k*W +: W] = word[k*W +: W];
      end else begin
        s = 0;
        foreach (grp[i]) begin
          word = grp[i];
          v = word[k*W +: W];
          s += sx(v);
        end
        s = s >>> m_sh;
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        r[k*W +: W] = s[W-1:0];
      end
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    exp_ready = 1'b0;
    if (!rst_n) begin
      grp.delete();
      exp_data = '0;
    end else begin
      if (sync) grp.delete();
      if (ready) begin
        if (grp.size() == 0) begin
          m_r = clampr(int'(ratio));
          m_mode = mode;
          m_sh = int'(shift);
        end
        grp.push_back(data);
        if (grp.size() == m_r) begin
          exp_data = group_result();
          exp_ready = 1'b1;
          grp.delete();
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("o_ready", longint'(o_ready), longint'(exp_ready));
      chk("o_data", longint'(o_data), longint'(exp_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int a, input int b);
    ready = 1'b1;
    data  = {W'(b), W'(a)};
    step();
    ready = 1'b0;
  endtask

  initial begin
    step();
    step();
    check_en = 1'b1;
    chk("reset_o_ready", longint'(o_ready), 0);
    chk("reset_o_data", longint'(o_data), 0);
    rst_n = 1'b1;
    step();

    // 1: pick, R=4, ramp
    ratio = RW'(4); mode = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      strobe(n, -n);
      if (n % 4 == 0) begin
        chk("t1_ready", longint'(o_ready), 1);
        chk("t1_ch0", och(0), n);
        chk("t1_ch1", och(1), -n);
      end
    end
    step();

    // 2: average, R=4, shift 2, then floor cases
    mode = 1'b1; shift = 5'd2;
    for (int n = 0; n < 4; n++) strobe(1000, -3);
    chk("t2_ch0", och(0), 1000);
    chk("t2_ch1", och(1), -3);
    for (int n = 0; n < 4; n++) strobe(1000, -1);
    chk("t2_floor_ch1", och(1), -1);
    shift = 5'd3;
    for (int n = 0; n < 4; n++) strobe(1000, -1);
    chk("t2_sh3_ch0", och(0), 500);
    chk("t2_sh3_ch1", och(1), -1);
    step();

    // 3: saturation at R=256
    ratio = RW'(256); shift = 5'd0;
    for (int n = 0; n < 256; n++) strobe(262143, 262143);
    chk("t3_pos_ready", longint'(o_ready), 1);
    chk("t3_pos_ch0", och(0), 262143);
    chk("t3_pos_ch1", och(1), 262143);
    for (int n = 0; n < 256; n++) strobe(-262144, -262144);
    chk("t3_neg_ch0", och(0), -262144);
    chk("t3_neg_ch1", och(1), -262144);
    step();

    // 4: gapped strobes, R=3, pick
    ratio = RW'(3); mode = 1'b0;
    for (int s = 1; s <= 9; s++) begin
      strobe(s * 10, -s * 10);
      if (s % 3 == 0) begin
        chk("t4_ready", longint'(o_ready), 1);
        chk("t4_ch0", och(0), s * 10);
      end
      step();
      step();
      if (s % 3 == 0) chk("t4_hold_ch0", och(0), s * 10);
    end

    // 5: ratio change mid-group, then ratio 0
    ratio = RW'(4);
    strobe(1, 0); strobe(2, 0);
    ratio = RW'(2);
    strobe(3, 0); chk("t5_s3_ready", longint'(o_ready), 0);
    strobe(4, 0); chk("t5_s4_ready", longint'(o_ready), 1); chk("t5_s4_ch0", och(0), 4);
    strobe(5, 0); chk("t5_s5_ready", longint'(o_ready), 0);
    strobe(6, 0); chk("t5_s6_ready", longint'(o_ready), 1); chk("t5_s6_ch0", och(0), 6);
    ratio = '0;
    strobe(7, 0); chk("t5_r0a_ready", longint'(o_ready), 1); chk("t5_r0a_ch0", och(0), 7);
    strobe(8, 0); chk("t5_r0b_ready", longint'(o_ready), 1); chk("t5_r0b_ch0", och(0), 8);
    step();

    // 6: sync on strobe 3, then reset on strobe 2 of next group
    ratio = RW'(4);
    strobe(1, 0); strobe(2, 0);
    sync = 1'b1;
    strobe(3, 0);
    sync = 1'b0;
    chk("t6_sync_ready", longint'(o_ready), 0);
    strobe(4, 0); strobe(5, 0);
    chk("t6_pre_ready", longint'(o_ready), 0);
    strobe(6, 0);
    chk("t6_out_ready", longint'(o_ready), 1);
    chk("t6_out_ch0", och(0), 6);
    strobe(7, 0);
    rst_n = 1'b0;
    strobe(8, 0);
    rst_n = 1'b1;
    chk("t6_rst_ready", longint'(o_ready), 0);
    chk("t6_rst_data", longint'(o_data), 0);
    strobe(9, 0); strobe(10, 0); strobe(11, 0);
    chk("t6_post_pre_ready", longint'(o_ready), 0);
    strobe(12, 0);
    chk("t6_post_ready", longint'(o_ready), 1);
    chk("t6_post_ch0", och(0), 12);
    step();
    step();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
